// File: rtl/tabby_mailbox_pkg.sv
// Purpose: shared constants for the tabby mailbox (register offsets, STATUS and
//          IRQ bit positions) plus the byte-lane mask helper.
// Ports:   none (package).
package tabby_mailbox_pkg;

  localparam int unsigned MB_DATA_W = 32;
  localparam int unsigned MB_ADDR_W = 3;
  localparam int unsigned MB_BE_W   = 4;

  // Word offsets in the host window
  localparam logic [MB_ADDR_W-1:0] OFF_TXDATA   = 3'd0;
  localparam logic [MB_ADDR_W-1:0] OFF_RXDATA   = 3'd1;
  localparam logic [MB_ADDR_W-1:0] OFF_STATUS   = 3'd2;
  localparam logic [MB_ADDR_W-1:0] OFF_IRQ_EN   = 3'd3;
  localparam logic [MB_ADDR_W-1:0] OFF_IRQ_PEND = 3'd4;
  localparam logic [MB_ADDR_W-1:0] OFF_SCRATCH  = 3'd5;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_FULL    = 2;
  localparam int unsigned ST_RX_EMPTY   = 3;
  localparam int unsigned ST_TX_OVF     = 4;
  localparam int unsigned ST_RX_UNF     = 5;
  localparam int unsigned ST_TX_LVL_LSB = 8;
  localparam int unsigned ST_RX_LVL_LSB = 16;

  // IRQ_EN / IRQ_PEND bit positions
  localparam int unsigned IRQ_RX_NE = 0;
  localparam int unsigned IRQ_TX_E  = 1;
  localparam int unsigned IRQ_ERR   = 2;
  localparam int unsigned IRQ_W     = 3;

  // Expand byte enables into a 32-bit lane mask
  function automatic logic [MB_DATA_W-1:0] be_mask(input logic [MB_BE_W-1:0] be);
    logic [MB_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MB_BE_W); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tabby_mailbox_if.sv
// Purpose: bundles the mailbox Avalon-MM slave, TX/RX Avalon-ST and IRQ signals.
// Modports: master = host bridge + fabric side, slave = the mailbox itself.
interface tabby_mailbox_if;
  import tabby_mailbox_pkg::*;

  logic [MB_ADDR_W-1:0] avs_S1_address;
  logic [MB_DATA_W-1:0] avs_S1_writedata;
  logic [MB_BE_W-1:0]   avs_S1_byteenable;
  logic                 avs_S1_write;
  logic                 avs_S1_read;
  logic [MB_DATA_W-1:0] avs_S1_readdata;
  logic                 avs_S1_readdatavalid;
  logic                 avs_S1_waitrequest;
  logic [MB_DATA_W-1:0] aso_TX_data;
  logic                 aso_TX_valid;
  logic                 aso_TX_ready;
  logic [MB_DATA_W-1:0] asi_RX_data;
  logic                 asi_RX_valid;
  logic                 asi_RX_ready;
  logic                 ins_IRQ_irq;

  modport master (
    output avs_S1_address, avs_S1_writedata, avs_S1_byteenable, avs_S1_write, avs_S1_read,
    input  avs_S1_readdata, avs_S1_readdatavalid, avs_S1_waitrequest,
    input  aso_TX_data, aso_TX_valid,
    output aso_TX_ready,
    output asi_RX_data, asi_RX_valid,
    input  asi_RX_ready,
    input  ins_IRQ_irq
  );

  modport slave (
    input  avs_S1_address, avs_S1_writedata, avs_S1_byteenable, avs_S1_write, avs_S1_read,
    output avs_S1_readdata, avs_S1_readdatavalid, avs_S1_waitrequest,
    output aso_TX_data, aso_TX_valid,
    input  aso_TX_ready,
    input  asi_RX_data, asi_RX_valid,
    output asi_RX_ready,
    output ins_IRQ_irq
  );

endinterface

// File: rtl/tabby_sync_fifo.sv
// Purpose: single-clock show-ahead FIFO. The parent guarantees push only when
//          not full and pop only when not empty.
// Ports:   i_clk, i_rst (async, active-high), i_push/i_data, i_pop,
//          o_head (0 when empty), o_full, o_empty, o_level.
module tabby_sync_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);
  import tabby_mailbox_pkg::*;

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;

  // Pointers wrap naturally at 2**DEPTH_LOG2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; contents are invalid whenever level is zero
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_level = r_level;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/tabby_mailbox.sv
// Purpose: Avalon-MM mailbox: host writes feed a TX FIFO drained by an ST
//          source; an ST sink fills an RX FIFO read by the host. Level/error IRQ.
// Ports:   csi_MCLK_clk, rsi_MRST_reset (async, active-high),
//          bus (tabby_mailbox_if.slave): S1 MM slave, TX source, RX sink, IRQ.
module tabby_mailbox #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic            csi_MCLK_clk,
  input  logic            rsi_MRST_reset,
  tabby_mailbox_if.slave  bus
);
  import tabby_mailbox_pkg::*;

  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic              r_waitreq;
  logic              r_rdv;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_scratch;
  logic [IRQ_W-1:0]  r_irq_en;
  logic              r_tx_ovf;
  logic              r_rx_unf;
  logic              r_irq;

  logic              w_wr_acc, w_rd_acc;
  logic              w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic              w_rx_rd, w_rx_push, w_rx_pop, w_rx_unf_set;
  logic              w_err_clr;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [LVL_W-1:0]  w_tx_level, w_rx_level;
  logic [DATA_W-1:0] w_tx_head, w_rx_head;
  logic [DATA_W-1:0] w_wdata_m;
  logic [DATA_W-1:0] w_be_m;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_mux;
  logic [IRQ_W-1:0]  w_irq_pend;

  assign w_wr_acc = bus.avs_S1_write & ~r_waitreq;
  assign w_rd_acc = bus.avs_S1_read  & ~r_waitreq;
  assign w_be_m    = DATA_W'(be_mask(bus.avs_S1_byteenable));
  assign w_wdata_m = DATA_W'(bus.avs_S1_writedata) & w_be_m;

  // Full/empty are start-of-cycle state: a push to a full FIFO is dropped
  // even if a pop happens the same cycle
  assign w_tx_wr      = w_wr_acc && (bus.avs_S1_address == OFF_TXDATA);
  assign w_tx_push    = w_tx_wr & ~w_tx_full;
  assign w_tx_ovf_set = w_tx_wr & w_tx_full;
  assign w_tx_pop     = bus.aso_TX_ready & ~w_tx_empty;

  assign w_rx_push    = bus.asi_RX_valid & ~w_rx_full;
  assign w_rx_rd      = w_rd_acc && (bus.avs_S1_address == OFF_RXDATA);
  assign w_rx_pop     = w_rx_rd & ~w_rx_empty;
  assign w_rx_unf_set = w_rx_rd & w_rx_empty;

  assign w_err_clr = w_wr_acc && (bus.avs_S1_address == OFF_IRQ_PEND)
                     && bus.avs_S1_writedata[IRQ_ERR];

  tabby_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .i_clk   (csi_MCLK_clk),
    .i_rst   (rsi_MRST_reset),
    .i_push  (w_tx_push),
    .i_data  (w_wdata_m),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (w_tx_level)
  );

  tabby_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .i_clk   (csi_MCLK_clk),
    .i_rst   (rsi_MRST_reset),
    .i_push  (w_rx_push),
    .i_data  (DATA_W'(bus.asi_RX_data)),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (w_rx_level)
  );

  // Pending causes: RX has data, TX drained, sticky error
  always_comb begin
    w_irq_pend            = '0;
    w_irq_pend[IRQ_RX_NE] = ~w_rx_empty;
    w_irq_pend[IRQ_TX_E]  = w_tx_empty;
    w_irq_pend[IRQ_ERR]   = r_tx_ovf | r_rx_unf;
  end

  // STATUS word assembly
  always_comb begin
    w_status                         = '0;
    w_status[ST_TX_FULL]             = w_tx_full;
    w_status[ST_TX_EMPTY]            = w_tx_empty;
    w_status[ST_RX_FULL]             = w_rx_full;
    w_status[ST_RX_EMPTY]            = w_rx_empty;
    w_status[ST_TX_OVF]              = r_tx_ovf;
    w_status[ST_RX_UNF]              = r_rx_unf;
    w_status[ST_TX_LVL_LSB +: 8]     = 8'(w_tx_level);
    w_status[ST_RX_LVL_LSB +: 8]     = 8'(w_rx_level);
  end

  // Read mux; RXDATA head is already 0 when the RX FIFO is empty
  always_comb begin
    w_rd_mux = '0;
    case (bus.avs_S1_address)
      OFF_RXDATA:   w_rd_mux = w_rx_head;
      OFF_STATUS:   w_rd_mux = w_status;
      OFF_IRQ_EN:   w_rd_mux = DATA_W'(r_irq_en);
      OFF_IRQ_PEND: w_rd_mux = DATA_W'(w_irq_pend);
      OFF_SCRATCH:  w_rd_mux = r_scratch;
      default:      w_rd_mux = '0;
    endcase
  end

  // Host-side registers; sticky set beats a same-cycle W1C
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_waitreq <= 1'b1;
      r_rdv     <= 1'b0;
      r_rdata   <= '0;
      r_scratch <= '0;
      r_irq_en  <= '0;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_waitreq <= 1'b0;
      r_rdv     <= w_rd_acc;
      r_rdata   <= w_rd_acc ? w_rd_mux : '0;
      if (w_wr_acc && (bus.avs_S1_address == OFF_SCRATCH))
        r_scratch <= (r_scratch & ~w_be_m) | w_wdata_m;
      if (w_wr_acc && (bus.avs_S1_address == OFF_IRQ_EN))
        r_irq_en <= bus.avs_S1_writedata[IRQ_W-1:0];
      r_tx_ovf  <= w_tx_ovf_set | (r_tx_ovf & ~w_err_clr);
      r_rx_unf  <= w_rx_unf_set | (r_rx_unf & ~w_err_clr);
      r_irq     <= |(w_irq_pend & r_irq_en);
    end
  end

  assign bus.avs_S1_readdata      = MB_DATA_W'(r_rdata);
  assign bus.avs_S1_readdatavalid = r_rdv;
  assign bus.avs_S1_waitrequest   = r_waitreq;
  assign bus.aso_TX_data          = MB_DATA_W'(w_tx_head);
  assign bus.aso_TX_valid         = ~w_tx_empty;
  assign bus.asi_RX_ready         = ~w_rx_full;
  assign bus.ins_IRQ_irq          = r_irq;

endmodule

// File: tb/tb_tabby_mailbox.sv
// Purpose: directed self-checking bench for tabby_mailbox (DEPTH_LOG2 = 4).
module tb_tabby_mailbox;
  import tabby_mailbox_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tabby_mailbox_if ifc();

  tabby_mailbox #(.DEPTH_LOG2(4), .DATA_W(32)) u_dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .bus            (ifc.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic rdv_seen = 1'b0;
  logic [31:0] rd;

  // Flags any readdatavalid pulse inside the reset-abort window
  always @(ifc.avs_S1_readdatavalid) begin
    if (mon_en && ifc.avs_S1_readdatavalid) rdv_seen = 1'b1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    ifc.avs_S1_address   = a;
    ifc.avs_S1_writedata = d;
    ifc.avs_S1_byteenable = be;
    ifc.avs_S1_write     = 1'b1;
    tick();
    ifc.avs_S1_write     = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [31:0] d);
    ifc.avs_S1_address = a;
    ifc.avs_S1_read    = 1'b1;
    tick();
    ifc.avs_S1_read    = 1'b0;
    chk_eq("rdv", 32'(ifc.avs_S1_readdatavalid), 32'd1);
    d = ifc.avs_S1_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rx [4];
    exp_rx[0] = 32'd1; exp_rx[1] = 32'd2; exp_rx[2] = 32'd3; exp_rx[3] = 32'd0;

    ifc.avs_S1_address    = '0;
    ifc.avs_S1_writedata  = '0;
    ifc.avs_S1_byteenable = '0;
    ifc.avs_S1_write      = 1'b0;
    ifc.avs_S1_read       = 1'b0;
    ifc.aso_TX_ready      = 1'b0;
    ifc.asi_RX_data       = '0;
    ifc.asi_RX_valid      = 1'b0;

    // 1: reset values and release
    repeat (3) tick();
    chk_eq("rst_waitreq", 32'(ifc.avs_S1_waitrequest), 32'd1);
    chk_eq("rst_rdv", 32'(ifc.avs_S1_readdatavalid), 32'd0);
    chk_eq("rst_rdata", ifc.avs_S1_readdata, 32'd0);
    chk_eq("rst_irq", 32'(ifc.ins_IRQ_irq), 32'd0);
    chk_eq("rst_tx_valid", 32'(ifc.aso_TX_valid), 32'd0);
    chk_eq("rst_tx_data", ifc.aso_TX_data, 32'd0);
    chk_eq("rst_rx_ready", 32'(ifc.asi_RX_ready), 32'd1);
    rst = 1'b0;
    chk_eq("rel_waitreq_hi", 32'(ifc.avs_S1_waitrequest), 32'd1);
    tick();
    chk_eq("rel_waitreq_lo", 32'(ifc.avs_S1_waitrequest), 32'd0);
    host_read(OFF_STATUS, rd);
    chk_eq("status_reset", rd, 32'h0000_000A);

    // 2: masked TX push and single pop
    host_write(OFF_TXDATA, 32'hDEAD_BEEF, 4'b0011);
    chk_eq("tx_valid_1", 32'(ifc.aso_TX_valid), 32'd1);
    chk_eq("tx_data_masked", ifc.aso_TX_data, 32'h0000_BEEF);
    host_read(OFF_STATUS, rd);
    chk_eq("status_tx1", rd, 32'h0000_0108);
    ifc.aso_TX_ready = 1'b1;
    tick();
    ifc.aso_TX_ready = 1'b0;
    chk_eq("tx_valid_0", 32'(ifc.aso_TX_valid), 32'd0);

    // 3: TX overflow, error IRQ, W1C
    for (int i = 0; i < 16; i++) host_write(OFF_TXDATA, 32'(i + 1), 4'hF);
    host_read(OFF_STATUS, rd);
    chk_eq("status_tx_full", rd, 32'h0000_1009);
    host_write(OFF_TXDATA, 32'h0000_0099, 4'hF);
    host_read(OFF_STATUS, rd);
    chk_eq("status_tx_ovf", rd, 32'h0000_1019);
    host_write(OFF_IRQ_EN, 32'd4, 4'hF);
    chk_eq("irq_lag", 32'(ifc.ins_IRQ_irq), 32'd0);
    tick();
    chk_eq("irq_err_on", 32'(ifc.ins_IRQ_irq), 32'd1);
    host_read(OFF_IRQ_PEND, rd);
    chk_eq("pend_err", rd, 32'd4);
    host_write(OFF_IRQ_PEND, 32'd4, 4'hF);
    tick();
    chk_eq("irq_err_off", 32'(ifc.ins_IRQ_irq), 32'd0);
    host_read(OFF_IRQ_PEND, rd);
    chk_eq("pend_clr", rd, 32'd0);
    ifc.aso_TX_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_eq("tx_drain", ifc.aso_TX_data, 32'(i + 1));
      tick();
    end
    ifc.aso_TX_ready = 1'b0;
    chk_eq("tx_drained", 32'(ifc.aso_TX_valid), 32'd0);

    // 4: RX push 1,2,3 then four back-to-back RXDATA reads
    ifc.asi_RX_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.asi_RX_data = 32'(i + 1);
      tick();
    end
    ifc.asi_RX_valid = 1'b0;
    ifc.avs_S1_address = OFF_RXDATA;
    ifc.avs_S1_read    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_eq("rx_rdv", 32'(ifc.avs_S1_readdatavalid), 32'd1);
      chk_eq("rx_data", ifc.avs_S1_readdata, exp_rx[k]);
    end
    ifc.avs_S1_read = 1'b0;
    host_read(OFF_STATUS, rd);
    chk_eq("status_rx_unf", rd, 32'h0000_002A);
    chk_eq("irq_unf", 32'(ifc.ins_IRQ_irq), 32'd1);
    tick();
    chk_eq("rdv_idle", 32'(ifc.avs_S1_readdatavalid), 32'd0);
    host_write(OFF_IRQ_PEND, 32'd4, 4'hF);
    tick();
    chk_eq("irq_unf_clr", 32'(ifc.ins_IRQ_irq), 32'd0);

    // 5: RX full, host pop while fabric still offers data
    ifc.asi_RX_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifc.asi_RX_data = 32'h100 + 32'(i);
      tick();
    end
    ifc.asi_RX_data = 32'h0000_0999;
    chk_eq("rx_ready_full", 32'(ifc.asi_RX_ready), 32'd0);
    host_read(OFF_STATUS, rd);
    chk_eq("status_rx_full", rd, 32'h0010_0006);
    ifc.avs_S1_address = OFF_RXDATA;
    ifc.avs_S1_read    = 1'b1;
    chk_eq("rx_ready_pop_cycle", 32'(ifc.asi_RX_ready), 32'd0);
    tick();
    ifc.avs_S1_read  = 1'b0;
    ifc.asi_RX_valid = 1'b0;
    chk_eq("rx_pop_rdv", 32'(ifc.avs_S1_readdatavalid), 32'd1);
    chk_eq("rx_pop_data", ifc.avs_S1_readdata, 32'h0000_0100);
    host_read(OFF_STATUS, rd);
    chk_eq("status_rx_15", rd, 32'h000F_0002);
    host_read(OFF_RXDATA, rd);
    chk_eq("rx_next", rd, 32'h0000_0101);

    // SCRATCH byte lanes and unmapped offsets
    host_write(OFF_SCRATCH, 32'h1234_5678, 4'hF);
    host_write(OFF_SCRATCH, 32'hAABB_CCDD, 4'b0101);
    host_read(OFF_SCRATCH, rd);
    chk_eq("scratch_be", rd, 32'h12BB_56DD);
    host_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    host_read(3'd6, rd);
    chk_eq("off6_zero", rd, 32'd0);
    host_read(OFF_TXDATA, rd);
    chk_eq("txdata_rd_zero", rd, 32'd0);
    host_read(OFF_IRQ_EN, rd);
    chk_eq("irq_en_rb", rd, 32'd4);

    // 6: reset with a TX word pending and a read request outstanding
    host_write(OFF_TXDATA, 32'h0000_0055, 4'hF);
    chk_eq("tx_pending", 32'(ifc.aso_TX_valid), 32'd1);
    mon_en = 1'b1;
    ifc.avs_S1_address = OFF_SCRATCH;
    ifc.avs_S1_read    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    ifc.avs_S1_read = 1'b0;
    chk_eq("abort_rdv", 32'(ifc.avs_S1_readdatavalid), 32'd0);
    chk_eq("abort_tx_valid", 32'(ifc.aso_TX_valid), 32'd0);
    chk_eq("abort_waitreq", 32'(ifc.avs_S1_waitrequest), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b0;
    chk_eq("abort_no_rdv", 32'(rdv_seen), 32'd0);
    chk_eq("post_tx_valid", 32'(ifc.aso_TX_valid), 32'd0);
    chk_eq("post_tx_data", ifc.aso_TX_data, 32'd0);
    host_read(OFF_SCRATCH, rd);
    chk_eq("post_scratch", rd, 32'd0);
    host_read(OFF_STATUS, rd);
    chk_eq("post_status", rd, 32'h0000_000A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
